global_events_ctrl: RTL and testbench

- System-side endpoint of the global events interface, one instance per hart.
- Drives `cache_miss` and `hart_id` to the pipeline.
- Consumes the pipeline's `thread_terminated`. On termination it runs a cache flush handshake, with a timeout, and then parks the hart in a terminal halted state for the testbench/host.

---
 rtl/global_events_ctrl.sv | 113 +++++++++++
 tb/tb_global_events_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/global_events_ctrl.sv
// Global events endpoint for one hart: merges cache misses, runs the post-termination
// cache flush handshake with a timeout, then parks the hart in HALTED until reset.
// Optional miss-cycle statistics counter enabled by `define GLOBAL_EVENTS_MISS_COUNT_EN.
module global_events_ctrl #(
  parameter int unsigned HART_ID       = 0,
  parameter int unsigned FLUSH_TIMEOUT = 1024   // legal range 2..65535
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        icache_miss,
  input  logic        dcache_miss,
  input  logic        thread_terminated,
  input  logic        flush_done,
  output logic        cache_miss,
  output logic [31:0] hart_id,
  output logic        flush_req,
  output logic        halt,
  output logic        flush_timeout,
  output logic [31:0] miss_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Value the timer holds on the last permitted FLUSH cycle.
  localparam logic [15:0] TIMER_LAST = 16'(FLUSH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_RUN;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every next-state signal gets a default before the case so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (thread_terminated) begin
          state_d = ST_FLUSH;
          timer_d = '0;
        end
      end
      ST_FLUSH: begin
        timer_d = timer_q + 16'd1;
        // flush_done takes priority over a simultaneous timeout.
        if (flush_done) begin
          state_d = ST_HALTED;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign hart_id       = 32'(HART_ID);
  assign cache_miss    = (icache_miss | dcache_miss) & (state_q == ST_RUN);
  assign flush_req     = (state_q == ST_FLUSH);
  assign halt          = (state_q == ST_HALTED);
  assign flush_timeout = timeout_q;

`ifdef GLOBAL_EVENTS_MISS_COUNT_EN
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [32:0] miss_sum;

  // Counts miss-cycles (0, 1 or 2 per cycle) and saturates at all-ones.
  always_comb begin
    miss_sum   = {1'b0, miss_cnt_q} + 33'(icache_miss) + 33'(dcache_miss);
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_RUN) begin
      miss_cnt_d = miss_sum[32] ? '1 : miss_sum[31:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_global_events_ctrl.sv
// Self-checking bench for global_events_ctrl: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_global_events_ctrl;

  localparam int unsigned HART_ID       = 3;
  localparam int unsigned FLUSH_TIMEOUT = 8;
  localparam longint      MISS_MAX      = 64'h0000_0000_FFFF_FFFF;

`ifdef GLOBAL_EVENTS_MISS_COUNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        icache_miss, dcache_miss, thread_terminated, flush_done;
  logic        cache_miss, flush_req, halt, flush_timeout;
  logic [31:0] hart_id, miss_count;

  int checks = 0;
  int passes = 0;

  global_events_ctrl #(
    .HART_ID      (HART_ID),
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .icache_miss      (icache_miss),
    .dcache_miss      (dcache_miss),
    .thread_terminated(thread_terminated),
    .flush_done       (flush_done),
    .cache_miss       (cache_miss),
    .hart_id          (hart_id),
    .flush_req        (flush_req),
    .halt             (halt),
    .flush_timeout    (flush_timeout),
    .miss_count       (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: flush phase tracked by age in cycles, miss count as a capped sum.
  bit        m_flush, m_halted, m_to;
  int        m_age;
  longint    m_miss;
  longint    nxt;
  bit        preload_req = 1'b0;
  longint    preload_val = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_flush  <= 1'b0;
      m_halted <= 1'b0;
      m_to     <= 1'b0;
      m_age    <= 0;
      m_miss   <= 0;
    end else if (preload_req) begin
      m_miss <= preload_val;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_flush) begin
      if (flush_done) begin
        m_flush  <= 1'b0;
        m_halted <= 1'b1;
      end else if (m_age + 1 == int'(FLUSH_TIMEOUT)) begin
        m_flush  <= 1'b0;
        m_halted <= 1'b1;
        m_to     <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      nxt = m_miss + longint'(icache_miss) + longint'(dcache_miss);
      if (nxt > MISS_MAX) nxt = MISS_MAX;
      m_miss <= nxt;
      if (thread_terminated) begin
        m_flush <= 1'b1;
        m_age   <= 0;
      end
    end
  end

  // Compare process plus cycle counters used by the directed checks.
  int flush_cycles = 0;
  int miss_cycles  = 0;

  always @(negedge CLK) begin
    check("hart_id", hart_id, 32'(HART_ID));
    check("cache_miss", 32'(cache_miss),
          32'((icache_miss | dcache_miss) & ~m_flush & ~m_halted));
    check("flush_req", 32'(flush_req), 32'(m_flush));
    check("halt", 32'(halt), 32'(m_halted));
    check("flush_timeout", 32'(flush_timeout), 32'(m_to));
    if (!preload_req) check("miss_count", miss_count, MISS_EN ? m_miss[31:0] : 32'h0);
    if (flush_req === 1'b1) flush_cycles++;
    if (cache_miss === 1'b1) miss_cycles++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_inputs();
    icache_miss       = 1'b0;
    dcache_miss       = 1'b0;
    thread_terminated = 1'b0;
    flush_done        = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    step(2);
    nRST = 1'b1;
    step(1);
  endtask

  task automatic terminate();
    thread_terminated = 1'b1;
    step(1);
    thread_terminated = 1'b0;
  endtask

  int base;

  initial begin
    clear_inputs();
    nRST = 1'b1;
    #2 nRST = 1'b0;

    // Reset / idle
    step(3);
    check("rst_hart_id", hart_id, 32'h3);
    check("rst_flush_req", 32'(flush_req), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_timeout", 32'(flush_timeout), 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    nRST = 1'b1;
    step(2);
    check("idle_cache_miss", 32'(cache_miss), 32'h0);

    // Miss merge: icache 4 cycles, dcache overlapping the last 2
    base = miss_cycles;
    icache_miss = 1'b1;
    step(2);
    dcache_miss = 1'b1;
    check("merge_comb", 32'(cache_miss), 32'h1);
    step(2);
    clear_inputs();
    step(1);
    @(negedge CLK);
    #1;
    check("merge_cycles", 32'(miss_cycles - base), 32'd4);
    check("merge_count", miss_count, MISS_EN ? 32'd6 : 32'd0);

    // Normal termination: flush_done on the 5th FLUSH cycle
    base = flush_cycles;
    terminate();
    check("term_flush_req", 32'(flush_req), 32'h1);
    step(4);
    flush_done = 1'b1;
    step(1);
    flush_done = 1'b0;
    check("term_halt_now", 32'(halt), 32'h1);
    check("term_flush_low", 32'(flush_req), 32'h0);
    step(2);
    check("term_flush_cycles", 32'(flush_cycles - base), 32'd5);
    check("term_timeout", 32'(flush_timeout), 32'h0);
    icache_miss = 1'b1;
    step(3);
    check("halted_cache_miss", 32'(cache_miss), 32'h0);
    check("halted_count", miss_count, MISS_EN ? 32'd6 : 32'd0);
    icache_miss = 1'b0;

    // Timeout: flush_done never arrives
    do_reset();
    base = flush_cycles;
    terminate();
    step(12);
    check("to_flush_cycles", 32'(flush_cycles - base), 32'd8);
    check("to_halt", 32'(halt), 32'h1);
    check("to_timeout", 32'(flush_timeout), 32'h1);
    flush_done = 1'b1;
    step(1);
    flush_done = 1'b0;
    step(2);
    check("to_late_done_halt", 32'(halt), 32'h1);
    check("to_late_done_timeout", 32'(flush_timeout), 32'h1);

    // Tie: flush_done on the 8th FLUSH cycle wins over timeout
    do_reset();
    base = flush_cycles;
    terminate();
    step(7);
    flush_done = 1'b1;
    step(1);
    flush_done = 1'b0;
    step(2);
    check("tie_flush_cycles", 32'(flush_cycles - base), 32'd8);
    check("tie_halt", 32'(halt), 32'h1);
    check("tie_timeout", 32'(flush_timeout), 32'h0);

    // Asynchronous reset on the 3rd FLUSH cycle
    do_reset();
    terminate();
    step(2);
    check("mid_flush_req", 32'(flush_req), 32'h1);
    nRST = 1'b0;
    #1;
    check("async_flush_req", 32'(flush_req), 32'h0);
    check("async_halt", 32'(halt), 32'h0);
    step(2);
    nRST = 1'b1;
    step(1);
    icache_miss = 1'b1;
    #1;
    check("post_rst_run", 32'(cache_miss), 32'h1);
    icache_miss = 1'b0;
    step(2);

`ifdef GLOBAL_EVENTS_MISS_COUNT_EN
    // Saturation from 0xFFFF_FFFE with both misses
    do_reset();
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    preload_val = 64'h0000_0000_FFFF_FFFE;
    preload_req = 1'b1;
    step(1);
    release dut.miss_cnt_q;
    preload_req = 1'b0;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    step(2);
    check("sat_value", miss_count, 32'hFFFF_FFFF);
    step(2);
    clear_inputs();
    step(1);
    check("sat_hold", miss_count, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
